mem_dump_reader: RTL and testbench

Reads a contiguous window of the data memory, one word at a time, and streams each word out over a valid/ready handshake. It drives the same combinational-read address port a `data_mem` instance exposes (`address`, `rd`), but only reads and never asserts a write enable. The typical use is the bench or debug path after the processor has written its results: the block replaces the CPU on the memory read port and dumps the memory image.

---
 rtl/mem_dump_reader_pkg.sv | 23 ++
 rtl/mem_dump_reader.sv | 140 ++++++++++++++
 tb/tb_mem_dump_reader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump_reader_pkg
//  Purpose  : Shared definitions for the memory dump reader: the FSM state
//             encoding, the memory word size in bytes, and the memory depth
//             that sets the width of the word index.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_dump_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int MEM_WORDS  = 64;
    localparam int INDEX_W    = $clog2(MEM_WORDS);

endpackage : mem_dump_reader_pkg
`default_nettype wire

// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump_reader
//  Purpose  : Walks a contiguous window of the data memory one word at a time
//             and streams each word out over a valid/ready handshake. Only
//             drives the read address port; it never writes memory.
//  Ports    : clk            - clock, rising edge active
//             reset          - asynchronous active-high reset
//             start          - begin a dump (sampled in IDLE only)
//             abort          - cancel a dump in progress (FETCH/SEND)
//             address_to_mem - word-aligned read address to the memory
//             data_from_mem  - combinational read data for address_to_mem
//             out_valid      - out_data/out_index hold a word to transfer
//             out_ready      - consumer accepts the word
//             out_data       - captured memory word
//             out_index      - word offset of out_data from BASE_ADDR
//             busy           - high while in FETCH or SEND
//             done           - one-cycle pulse after the last word is taken
//  Revision : 1.0 - initial release
// ============================================================================
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_WORDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        address_to_mem,
    input  logic [31:0]        data_from_mem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [INDEX_W-1:0] out_index,
    output logic               busy,
    output logic               done
);

    localparam logic [INDEX_W-1:0] C_LAST_IDX = INDEX_W'(NUM_WORDS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [INDEX_W-1:0] r_idx;
    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic [INDEX_W-1:0] r_out_index;
    logic [31:0]        w_offset;
    logic               w_last;

    assign w_last   = (r_idx == C_LAST_IDX);
    // Byte offset of the current word; the adder below wraps modulo 2^32.
    assign w_offset = 32'(r_idx) * 32'(WORD_BYTES);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. abort wins over a same-cycle handshake so the
    // word in flight counts as not transferred.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_next_state = abort ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (out_ready) begin
                    w_next_state = w_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: index counter and output capture registers.
    // out_valid is exactly "we are in SEND", so it is derived from the
    // next state; that clears it on handshake, on abort, and on reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
        end else begin
            r_out_valid <= (w_next_state == ST_SEND);

            if (r_state == ST_IDLE && start) begin
                r_idx <= '0;
            end

            if (r_state == ST_FETCH && !abort) begin
                r_out_data  <= data_from_mem;
                r_out_index <= r_idx;
            end

            // Advance only on a real handshake that is not the last word;
            // the index is left on the last word so DONE reports it.
            if (r_state == ST_SEND && !abort && out_ready && !w_last) begin
                r_idx <= r_idx + INDEX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered or decoded from state only.
    // ------------------------------------------------------------------
    assign address_to_mem = (r_state == ST_FETCH) ? (BASE_ADDR + w_offset) : BASE_ADDR;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_index      = r_out_index;
    assign busy           = (r_state == ST_FETCH) || (r_state == ST_SEND);
    assign done           = (r_state == ST_DONE);

endmodule : mem_dump_reader
`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_dump_reader
//  Purpose  : Self-checking bench for mem_dump_reader. Three instances cover
//             a 4-word dump from address 0, a 3-word dump that crosses the
//             64-word memory boundary, and a single-word dump.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dump_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Memory image shared by every instance: RAM[i] = A000_0000 + i.
    logic [31:0] ram [64];
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'hA000_0000 + 32'(i);
    end

    // Instance 0: BASE 0, 4 words
    logic        start0, abort0, ready0, valid0, busy0, done0;
    logic [31:0] addr0, rdata0, data0;
    logic [5:0]  index0;
    assign rdata0 = ram[addr0[7:2]];

    mem_dump_reader #(.BASE_ADDR(32'h0000_0000), .NUM_WORDS(4)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .address_to_mem(addr0), .data_from_mem(rdata0),
        .out_valid(valid0), .out_ready(ready0), .out_data(data0),
        .out_index(index0), .busy(busy0), .done(done0)
    );

    // Instance 1: BASE F8, 3 words (address crosses the 64-word image)
    logic        start1, abort1, ready1, valid1, busy1, done1;
    logic [31:0] addr1, rdata1, data1;
    logic [5:0]  index1;
    assign rdata1 = ram[addr1[7:2]];

    mem_dump_reader #(.BASE_ADDR(32'h0000_00F8), .NUM_WORDS(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .address_to_mem(addr1), .data_from_mem(rdata1),
        .out_valid(valid1), .out_ready(ready1), .out_data(data1),
        .out_index(index1), .busy(busy1), .done(done1)
    );

    // Instance 2: BASE 0, 1 word
    logic        start2, abort2, ready2, valid2, busy2, done2;
    logic [31:0] addr2, rdata2, data2;
    logic [5:0]  index2;
    assign rdata2 = ram[addr2[7:2]];

    mem_dump_reader #(.BASE_ADDR(32'h0000_0000), .NUM_WORDS(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .address_to_mem(addr2), .data_from_mem(rdata2),
        .out_valid(valid2), .out_ready(ready2), .out_data(data2),
        .out_index(index2), .busy(busy2), .done(done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One record per cycle: inputs driven this cycle, outputs expected
    // while those inputs are applied (outputs depend on state only).
    typedef struct {
        logic        start, ready, abort;
        logic        valid;
        logic [31:0] data;
        logic [5:0]  index;
        logic        busy, done;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic a, input logic v,
                       input logic [31:0] d, input logic [5:0] i,
                       input logic b, input logic dn, input logic [31:0] ad);
        vec_t x;
        x.start = s; x.ready = r; x.abort = a; x.valid = v; x.data = d;
        x.index = i; x.busy = b; x.done = dn; x.addr = ad;
        vecs.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] addrs[$];
        logic [31:0] words[$];
        logic [5:0]  idxs[$];
        logic        seen_done;
        int          nbusy, nwords, ndone;
        logic [31:0] w2_data;
        logic [5:0]  w2_idx;
        logic [31:0] exp_addr [3];
        logic [31:0] exp_word [3];

        reset  = 1'b1;
        start0 = 0; abort0 = 0; ready0 = 1;
        start1 = 0; abort1 = 0; ready1 = 1;
        start2 = 0; abort2 = 0; ready2 = 1;

        //   st rd ab | val  data           idx busy done addr
        // Plain dump, ready held high: done 8 cycles after the first FETCH
        add(1, 1, 0,   0, 32'h0,          0, 0, 0, 32'h0);  // 0  IDLE (reset state)
        add(0, 1, 0,   0, 32'h0,          0, 1, 0, 32'h0);  // 1  FETCH w0
        add(0, 1, 0,   1, 32'hA000_0000,  0, 1, 0, 32'h0);  // 2  SEND w0
        add(0, 1, 0,   0, 32'hA000_0000,  0, 1, 0, 32'h4);  // 3  FETCH w1
        add(0, 1, 0,   1, 32'hA000_0001,  1, 1, 0, 32'h0);  // 4  SEND w1
        add(0, 1, 0,   0, 32'hA000_0001,  1, 1, 0, 32'h8);  // 5  FETCH w2
        add(0, 1, 0,   1, 32'hA000_0002,  2, 1, 0, 32'h0);  // 6  SEND w2
        add(0, 1, 0,   0, 32'hA000_0002,  2, 1, 0, 32'hC);  // 7  FETCH w3
        add(0, 1, 0,   1, 32'hA000_0003,  3, 1, 0, 32'h0);  // 8  SEND w3
        add(0, 1, 0,   0, 32'hA000_0003,  3, 0, 1, 32'h0);  // 9  DONE
        // Second dump, stall 5 cycles on word 2; start while busy ignored
        add(1, 1, 0,   0, 32'hA000_0003,  3, 0, 0, 32'h0);  // 10 IDLE
        add(0, 1, 0,   0, 32'hA000_0003,  3, 1, 0, 32'h0);  // 11 FETCH w0
        add(1, 1, 0,   1, 32'hA000_0000,  0, 1, 0, 32'h0);  // 12 SEND w0
        add(1, 1, 0,   0, 32'hA000_0000,  0, 1, 0, 32'h4);  // 13 FETCH w1
        add(0, 1, 0,   1, 32'hA000_0001,  1, 1, 0, 32'h0);  // 14 SEND w1
        add(0, 1, 0,   0, 32'hA000_0001,  1, 1, 0, 32'h8);  // 15 FETCH w2
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 1, 32'hA000_0002, 2, 1, 0, 32'h0);  // 16-20 stalled
        add(0, 1, 0,   1, 32'hA000_0002,  2, 1, 0, 32'h0);  // 21 SEND w2 accepted
        add(0, 1, 0,   0, 32'hA000_0002,  2, 1, 0, 32'hC);  // 22 FETCH w3
        add(0, 1, 0,   1, 32'hA000_0003,  3, 1, 0, 32'h0);  // 23 SEND w3
        add(1, 1, 0,   0, 32'hA000_0003,  3, 0, 1, 32'h0);  // 24 DONE, start ignored
        // Abort in SEND with ready high, then start+abort in IDLE, abort in FETCH
        add(1, 1, 0,   0, 32'hA000_0003,  3, 0, 0, 32'h0);  // 25 IDLE
        add(0, 1, 0,   0, 32'hA000_0003,  3, 1, 0, 32'h0);  // 26 FETCH w0
        add(0, 1, 0,   1, 32'hA000_0000,  0, 1, 0, 32'h0);  // 27 SEND w0
        add(0, 1, 0,   0, 32'hA000_0000,  0, 1, 0, 32'h4);  // 28 FETCH w1
        add(0, 1, 1,   1, 32'hA000_0001,  1, 1, 0, 32'h0);  // 29 SEND w1 + abort
        add(1, 1, 1,   0, 32'hA000_0001,  1, 0, 0, 32'h0);  // 30 IDLE, start+abort
        add(0, 1, 0,   0, 32'hA000_0001,  1, 1, 0, 32'h0);  // 31 FETCH restarts at 0
        add(0, 1, 0,   1, 32'hA000_0000,  0, 1, 0, 32'h0);  // 32 SEND w0
        add(0, 1, 1,   0, 32'hA000_0000,  0, 1, 0, 32'h4);  // 33 FETCH w1 + abort
        add(0, 1, 0,   0, 32'hA000_0000,  0, 0, 0, 32'h0);  // 34 IDLE, no done
        add(0, 1, 0,   0, 32'hA000_0000,  0, 0, 0, 32'h0);  // 35 IDLE

        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("dut1 idle addr", addr1, 32'h0000_00F8);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            chk($sformatf("v%0d valid", k), 32'(valid0), 32'(vecs[k].valid));
            chk($sformatf("v%0d data",  k), data0,       vecs[k].data);
            chk($sformatf("v%0d index", k), 32'(index0), 32'(vecs[k].index));
            chk($sformatf("v%0d busy",  k), 32'(busy0),  32'(vecs[k].busy));
            chk($sformatf("v%0d done",  k), 32'(done0),  32'(vecs[k].done));
            chk($sformatf("v%0d addr",  k), addr0,       vecs[k].addr);
            start0 = vecs[k].start;
            ready0 = vecs[k].ready;
            abort0 = vecs[k].abort;
        end

        // ---- Asynchronous reset in the middle of FETCH of word 1 ----
        @(negedge clk); start0 = 0; abort0 = 0; ready0 = 1;
        start0 = 1;
        @(negedge clk); start0 = 0;             // FETCH w0
        @(negedge clk);                         // SEND w0
        @(negedge clk);                         // FETCH w1
        chk("rst pre addr", addr0, 32'h4);
        chk("rst pre data", data0, 32'hA000_0000);
        #2 reset = 1'b1;
        #1;
        chk("rst valid", 32'(valid0), 32'h0);
        chk("rst data",  data0,       32'h0);
        chk("rst index", 32'(index0), 32'h0);
        chk("rst busy",  32'(busy0),  32'h0);
        chk("rst done",  32'(done0),  32'h0);
        chk("rst addr",  addr0,       32'h0);
        #1 reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post rst busy",  32'(busy0),  32'h0);
            chk("post rst valid", 32'(valid0), 32'h0);
        end

        // ---- Address crossing the image boundary ----
        exp_addr[0] = 32'h0000_00F8; exp_word[0] = 32'hA000_003E;
        exp_addr[1] = 32'h0000_00FC; exp_word[1] = 32'hA000_003F;
        exp_addr[2] = 32'h0000_0100; exp_word[2] = 32'hA000_0000;
        seen_done = 1'b0;
        start1 = 1;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            @(negedge clk);
            start1 = 0;
            if (busy1 && !valid1) addrs.push_back(addr1);
            if (valid1 && ready1) begin
                words.push_back(data1);
                idxs.push_back(index1);
            end
            if (done1) seen_done = 1'b1;
        end
        chk("wrap done seen", 32'(seen_done), 32'h1);
        chk("wrap n_addr", 32'(addrs.size()), 32'd3);
        chk("wrap n_word", 32'(words.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap addr%0d", i), (i < addrs.size()) ? addrs[i] : 32'hxxxx_xxxx, exp_addr[i]);
            chk($sformatf("wrap word%0d", i), (i < words.size()) ? words[i] : 32'hxxxx_xxxx, exp_word[i]);
            chk($sformatf("wrap idx%0d", i), (i < idxs.size()) ? 32'(idxs[i]) : 32'hxxxx_xxxx, 32'(i));
        end

        // ---- Single-word dump ----
        nbusy = 0; nwords = 0; ndone = 0; w2_data = '0; w2_idx = '1;
        @(negedge clk);
        start2 = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start2 = 0;
            if (busy2) nbusy++;
            if (done2) ndone++;
            if (valid2 && ready2) begin
                nwords++;
                w2_data = data2;
                w2_idx  = index2;
            end
        end
        chk("n1 busy cycles", 32'(nbusy),  32'd2);
        chk("n1 words",       32'(nwords), 32'd1);
        chk("n1 done pulses", 32'(ndone),  32'd1);
        chk("n1 data",        w2_data,     32'hA000_0000);
        chk("n1 index",       32'(w2_idx), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_dump_reader
`default_nettype wire
